// File: rtl/audio_frame_capture.sv
// audio_frame_capture: samples a 12-bit offset-binary ADC channel at a fixed
// rate, waits for a sample whose magnitude reaches THRESHOLD, captures
// FRAME_LEN samples into a block RAM and then streams them out over a
// valid/ready interface.
// Optional feature: define SAMPLER_AVG2_EN to average each sample with the
// previous one (two-tap moving average) before triggering and capture.
module audio_frame_capture #(
    parameter int sys_clk_freq = 50000000,
    parameter int sample_rate  = 8000,
    parameter int FRAME_LEN    = 256,
    parameter int THRESHOLD    = 200
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [11:0]        adc_data,
    input  logic               arm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [11:0] out_data,
    output logic               out_last,
    output logic               busy,
    output logic               frame_done
);
    localparam int DIV   = sys_clk_freq / sample_rate;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW    = $clog2(FRAME_LEN);
    localparam int PTR_W = AW + 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
    localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(FRAME_LEN - 1);
    localparam logic [PTR_W-1:0] FRAME_END = PTR_W'(FRAME_LEN);
    localparam logic [12:0]      THRESH    = 13'(THRESHOLD);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

    // 13-bit magnitude so that -2048 maps to +2048 without overflow.
    function automatic logic [12:0] magnitude(input logic signed [11:0] s);
        logic signed [12:0] w;
        w = {s[11], s};
        return w[12] ? $unsigned(-w) : $unsigned(w);
    endfunction

    // Two-tap average: 13-bit sum, arithmetic shift right by one.
    function automatic logic signed [11:0] avg2(input logic signed [11:0] a,
                                                input logic signed [11:0] b);
        logic signed [12:0] sum;
        logic signed [12:0] sh;
        sum = $signed({a[11], a}) + $signed({b[11], b});
        sh  = sum >>> 1;
        return sh[11:0];
    endfunction

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tick;
    logic signed [11:0] s_cur_q;
    logic               samp_vld_q;
    logic signed [11:0] samp;
    logic               trig;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               frame_done_q, frame_done_d;
    logic signed [11:0] out_data_q;
    logic               load;
    logic               mem_we;
    logic [AW-1:0]      mem_waddr;

    logic signed [11:0] mem [FRAME_LEN];

    assign tick  = (cnt_q == CNT_MAX);
    assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    // Free-running sample-rate divider.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    // Register the ADC value as two's complement on each tick; flag it new.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_cur_q    <= '0;
            samp_vld_q <= 1'b0;
        end else begin
            samp_vld_q <= tick;
            if (tick) s_cur_q <= $signed({~adc_data[11], adc_data[10:0]});
        end
    end

`ifdef SAMPLER_AVG2_EN
    logic signed [11:0] s_prev_q;

    // Keep the previous sample for the two-tap average, in every state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  s_prev_q <= '0;
        else if (tick) s_prev_q <= s_cur_q;
    end

    assign samp = avg2(s_cur_q, s_prev_q);
`else
    assign samp = s_cur_q;
`endif

    assign trig = (magnitude(samp) >= THRESH);

    // Next-state, capture-write and drain-output decisions.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        mem_we       = 1'b0;
        mem_waddr    = wr_ptr_q[AW-1:0];
        load         = 1'b0;
        frame_done_d = 1'b0;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        case (state_q)
            IDLE: begin
                // An arm coinciding with the end-of-frame pulse is dropped.
                if (arm && !frame_done_q) state_d = ARMED;
            end
            ARMED: begin
                if (samp_vld_q && trig) begin
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                    wr_ptr_d  = PTR_W'(1);
                    state_d   = CAPTURE;
                end
            end
            CAPTURE: begin
                if (samp_vld_q) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    if (wr_ptr_q == LAST_IDX) begin
                        rd_ptr_d = '0;
                        state_d  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Fetch the next word whenever the output register is free
                // or being consumed this cycle.
                load = (!out_valid_q || out_ready) && (rd_ptr_q != FRAME_END);
                if (load) rd_ptr_d = rd_ptr_q + PTR_W'(1);
                if (out_valid_q && out_ready && out_last_q) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            out_valid_d = 1'b1;
            out_last_d  = (rd_ptr_q == LAST_IDX);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    // Control state, pointers and stream flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Frame memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= samp;
    end

    // Synchronous read with enable; the read register doubles as out_data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  out_data_q <= '0;
        else if (load) out_data_q <= mem[rd_ptr_q[AW-1:0]];
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_audio_frame_capture.sv
// Directed bench for audio_frame_capture with DIV=8, FRAME_LEN=4,
// THRESHOLD=100. Inputs are driven and outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_audio_frame_capture;
    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [11:0]        adc_data = 12'd2048;
    logic               arm = 1'b0;
    logic               out_ready = 1'b0;
    logic               out_valid;
    logic signed [11:0] out_data;
    logic               out_last;
    logic               busy;
    logic               frame_done;

    int checks = 0;
    int errors = 0;

    logic signed [11:0] got_data [8];
    logic               got_last [8];
    int                 hs_cyc   [8];

    always #5 clk = ~clk;

    audio_frame_capture #(
        .sys_clk_freq(80),
        .sample_rate (10),
        .FRAME_LEN   (4),
        .THRESHOLD   (100)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .adc_data  (adc_data),
        .arm       (arm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .frame_done(frame_done)
    );

    task automatic check(input string tag, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    // Present a value and return at the falling edge after it was sampled.
    task automatic feed(input logic [11:0] v);
        int n;
        n = 0;
        adc_data = v;
        while (dut.tick !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("tick_timeout", n, 0);
        @(negedge clk);
    endtask

    // Drive out_ready from a 4-cycle pattern, record handshakes and check
    // the whole frame against expectations.
    task automatic run_frame(input string tag, input logic [3:0] pat,
                             input bit arm_on_done, input bit need_burst,
                             input logic signed [11:0] e0, input logic signed [11:0] e1,
                             input logic signed [11:0] e2, input logic signed [11:0] e3);
        int                 n_hs;
        int                 done_cnt;
        int                 done_cyc;
        bit                 stalled;
        logic signed [11:0] prev_data;
        logic               prev_last;
        logic signed [11:0] exp_d [4];
        n_hs = 0; done_cnt = 0; done_cyc = -1; stalled = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        exp_d[0] = e0; exp_d[1] = e1; exp_d[2] = e2; exp_d[3] = e3;
        for (int i = 0; i < 60; i++) begin
            out_ready = pat[i % 4];
            if (stalled) begin
                check({tag, "_hold_data"}, out_data, prev_data);
                check({tag, "_hold_last"}, out_last, prev_last);
            end
            if (frame_done === 1'b1) begin
                done_cnt++;
                done_cyc = i;
                arm = arm_on_done;
            end else begin
                arm = 1'b0;
            end
            if (out_valid === 1'b1 && out_ready) begin
                if (n_hs < 8) begin
                    got_data[n_hs] = out_data;
                    got_last[n_hs] = out_last;
                    hs_cyc[n_hs]   = i;
                end
                n_hs++;
            end
            stalled   = (out_valid === 1'b1) && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            @(negedge clk);
        end
        arm = 1'b0;
        check({tag, "_handshakes"}, n_hs, 4);
        if (n_hs >= 4) begin
            for (int k = 0; k < 4; k++) begin
                check({tag, "_data"}, got_data[k], exp_d[k]);
                check({tag, "_last"}, got_last[k], (k == 3) ? 1 : 0);
            end
            check({tag, "_done_timing"}, done_cyc, hs_cyc[3] + 1);
            if (need_burst) check({tag, "_burst_span"}, hs_cyc[3] - hs_cyc[0], 3);
        end
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_valid_end"}, out_valid, 0);
    endtask

    initial begin
        int tick_cnt;
        int last_tick;
        int bad_gap;
        int vld_cnt;

        // Reset state
        #3;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_done", frame_done, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Divider: 64 cycles must hold exactly 8 evenly spaced ticks
        tick_cnt = 0; last_tick = -1; bad_gap = 0;
        for (int i = 0; i < 64; i++) begin
            if (dut.tick === 1'b1) begin
                if (last_tick >= 0 && (i - last_tick) != 8) bad_gap++;
                last_tick = i;
                tick_cnt++;
            end
            @(negedge clk);
        end
        check("tick_count", tick_cnt, 8);
        check("tick_gap_errors", bad_gap, 0);

`ifdef SAMPLER_AVG2_EN
        // Averaging: 0 then 300 averages to 150, which triggers
        out_ready = 1'b1;
        pulse_arm();
        feed(12'd2048);
        feed(12'd2348);
        check("avg_busy", busy, 1);
        feed(12'd2348);
        feed(12'd2048);
        feed(12'd2048);
        run_frame("avg", 4'b1111, 1'b0, 1'b1, 12'sd150, 12'sd300, 12'sd150, 12'sd0);
`else
        // Trigger: 52 discarded, 152 starts the frame
        out_ready = 1'b1;
        pulse_arm();
        check("armed_busy", busy, 1);
        feed(12'd2100);
        feed(12'd2200);
        feed(12'd2048);
        feed(12'd1900);
        feed(12'd1000);
        run_frame("trig", 4'b1111, 1'b0, 1'b1, 12'sd152, 12'sd0, -12'sd148, -12'sd1048);

        // Backpressure 1,0,0,1; an arm during frame_done must be dropped
        pulse_arm();
        feed(12'd2100);
        feed(12'd2200);
        feed(12'd2048);
        feed(12'd1900);
        feed(12'd1000);
        run_frame("bp", 4'b1001, 1'b1, 1'b0, 12'sd152, 12'sd0, -12'sd148, -12'sd1048);

        // Full-scale negative and positive codes
        out_ready = 1'b1;
        pulse_arm();
        feed(12'd0);
        feed(12'd2048);
        feed(12'd2048);
        feed(12'd4095);
        run_frame("zero", 4'b1111, 1'b0, 1'b1, -12'sd2048, 12'sd0, 12'sd0, 12'sd2047);

        // 99 must not trigger, 100 must; arm during CAPTURE is ignored
        pulse_arm();
        feed(12'd2147);
        check("below_thr_busy", busy, 1);
        feed(12'd2148);
        pulse_arm();
        feed(12'd1);
        feed(12'd2);
        feed(12'd3);
        run_frame("thr", 4'b1111, 1'b0, 1'b1, 12'sd100, -12'sd2047, -12'sd2046, -12'sd2045);
`endif

        // Reset mid-capture aborts the frame
        out_ready = 1'b1;
        pulse_arm();
        feed(12'd2200);
        feed(12'd2300);
        check("pre_rst_busy", busy, 1);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_done", frame_done, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        adc_data = 12'd3000;
        vld_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid !== 1'b0) vld_cnt++;
            @(negedge clk);
        end
        check("post_rst_valid_cycles", vld_cnt, 0);
        check("post_rst_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_frame_capture.md
AUDIO_FRAME_CAPTURE -- requirements
Module: audio_frame_capture

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- sys_clk_freq, 50000000, system clock in Hz.
- sample_rate, 8000, sampling rate in Hz; DIV = sys_clk_freq/sample_rate (integer).
- FRAME_LEN, 256, samples per frame; power of two, 4..1024.
- THRESHOLD, 200, trigger magnitude in LSB, range 0..2048.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  system clock.
- reset_n  in  1  reset.
- adc_data  in  12  unsigned offset-binary ADC channel value; quasi-static, may change at any cycle.
- arm  in  1  single-cycle request to capture one frame.
- out_valid  out  1  stream sample valid.
- out_ready  in  1  consumer ready.
- out_data  out  12  signed two's-complement sample.
- out_last  out  1  marks the final sample of a frame.
- busy  out  1  high when state is not IDLE.
- frame_done  out  1  one-cycle pulse after the last sample handshake.

REQ-003 The design SHALL use one clock, clk. Reset SHALL be reset_n, asynchronous and active-low.

Function
REQ-004 A divider SHALL count 0..DIV-1 and free-run in all states. tick SHALL be high for one cycle when the count equals DIV-1, and the count SHALL then wrap to 0.
REQ-005 On each tick, adc_data SHALL be registered as s_cur = adc_data - 2048, which is adc_data[11] inverted concatenated with adc_data[10:0].
REQ-006 The sample value used (samp) SHALL be as defined under Configuration. It SHALL be available the cycle after tick.
REQ-007 Trigger SHALL be |samp| >= THRESHOLD. The magnitude SHALL be computed at 13 bits, so |-2048| = 2048.
REQ-008 The state machine SHALL have four states: IDLE, ARMED, CAPTURE, DRAIN.
REQ-009 IDLE: an arm pulse SHALL move the state to ARMED. arm SHALL be ignored in all other states.
REQ-010 ARMED: on a new samp with trigger true, samp SHALL be written to mem[0], wr_ptr set to 1, and the state moved to CAPTURE. Samples with trigger false SHALL be discarded.
REQ-011 CAPTURE: every new samp SHALL be written to mem[wr_ptr] and wr_ptr incremented. After the write to mem[FRAME_LEN-1], the state SHALL move to DRAIN with rd_ptr = 0.
REQ-012 DRAIN: samples SHALL be streamed in order 0..FRAME_LEN-1. Ticks during DRAIN SHALL be discarded and SHALL NOT overwrite mem.
REQ-013 out_valid SHALL rise at most 2 cycles after entering DRAIN and SHALL stay high until the last handshake.
REQ-014 A handshake SHALL be out_valid && out_ready in the same cycle. While out_valid && !out_ready, out_data and out_last SHALL be held stable.
REQ-015 Back-to-back handshakes SHALL sustain 1 sample per cycle. A bubble-free stream is required when out_ready is held high.
REQ-016 out_last SHALL be high only with the sample at index FRAME_LEN-1.
REQ-017 On the last handshake: out_valid SHALL fall the next cycle, frame_done SHALL pulse for one cycle, and the state SHALL return to IDLE.
REQ-018 An arm pulse in the same cycle as frame_done SHALL be ignored.
REQ-019 The pointers SHALL be log2(FRAME_LEN) + 1 bits wide and SHALL never wrap within a frame.
REQ-020 The memory SHALL be inferable as block RAM with synchronous read.

Reset
REQ-021 When reset_n is low, the outputs SHALL asynchronously take: out_valid=0, out_data=0, out_last=0, busy=0, frame_done=0. Also state=IDLE, divider=0, wr_ptr=0, rd_ptr=0, s_cur=0, s_prev=0.
REQ-022 Memory contents SHALL NOT be reset.
REQ-023 Reset asserted mid-CAPTURE or mid-DRAIN SHALL abort the frame. After release, no out_valid SHALL appear until a new arm and trigger occur.

Configuration
REQ-024 Macro SAMPLER_AVG2_EN:
- Defined: samp = (s_cur + s_prev) >>> 1, computed with a 13-bit sum and arithmetic shift. s_prev SHALL update to s_cur on each tick in all states.
- Not defined: samp = s_cur, and no s_prev register SHALL exist.

Verification
Bench parameters for all scenarios: sys_clk_freq=80, sample_rate=10 (DIV=8), FRAME_LEN=4, THRESHOLD=100, macro undefined unless stated.
REQ-025 Divider: hold the bench 64 cycles after reset -> exactly 8 ticks, spaced 8 cycles apart.
REQ-026 Trigger: arm, then adc_data=2100, 2200, 2048, 1900, 1000 on successive ticks, out_ready=1 -> 2100 is discarded. The stream is 152, 0, -148, -1048, with out_last only on -1048, then frame_done, busy=0.
REQ-027 Backpressure: same capture, out_ready toggling 1,0,0,1 -> each sample held stable while stalled. Exactly 4 handshakes occur, in order.
REQ-028 Boundaries:
- adc_data=0 -> trigger fires, out_data = -2048.
- adc_data=2147 (|99|) -> no trigger.
- arm pulsed during CAPTURE -> ignored.
REQ-029 Reset: reset_n pulsed low after 2 captured samples -> all outputs 0 immediately. With no new arm, out_valid stays 0 for 100 cycles.
REQ-030 SAMPLER_AVG2_EN defined: prior tick at adc_data=2048, then adc_data=2348 -> samp=150, the trigger fires, and 150 is written to mem[0].
